// File: rtl/baudctrl_pkg.sv
// ============================================================================
//  Module      : baudctrl_pkg
//  Description : Shared constants for the baud-rate controller: default
//                widths and divisors, oversample ratio and FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package baudctrl_pkg;

    // Default divisor width and divisor values (100 MHz clock, 19200 baud, x16)
    localparam int C_NB_DIV_DEF = 10;
    localparam int C_DIV_DEF    = 326;
    localparam int C_DIV_MIN    = 2;

    // Oversample ratio: one bit period spans this many sample ticks
    localparam int C_OVERSAMPLE = 16;
    localparam int C_NB_OVS     = $clog2(C_OVERSAMPLE);

    // Divisor-update FSM encodings
    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_PENDING = 2'd1;
    localparam logic [1:0] C_ST_APPLY   = 2'd2;

endpackage : baudctrl_pkg

`default_nettype wire

// File: rtl/baudctrl_divcnt_module.sv
// ============================================================================
//  Module      : baudctrl_divcnt_module
//  Description : Modulo-divisor counter with a registered tick output. The
//                combinational wrap flag lets the parent sequence divisor
//                changes on the exact wrap cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baudctrl_divcnt_module #(
    parameter int NB_BAUDCTRL_DIV = 10
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_clear,
    input  logic [NB_BAUDCTRL_DIV-1:0] i_divisor,
    output logic                       o_tick,
    output logic                       o_wrap
);

    logic [NB_BAUDCTRL_DIV-1:0] r_cnt_q;
    logic                       r_tick_q;
    logic                       w_wrap;

    // Wrap happens on the last count of the period while counting is allowed
    assign w_wrap = i_enable && (r_cnt_q == (i_divisor - 1'b1));

    // Counter and tick register; clear wins so a new divisor starts from zero
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt_q  <= '0;
            r_tick_q <= 1'b0;
        end else if (i_clear) begin
            r_cnt_q  <= '0;
            r_tick_q <= 1'b0;
        end else if (w_wrap) begin
            r_cnt_q  <= '0;
            r_tick_q <= 1'b1;
        end else begin
            if (i_enable) begin
                r_cnt_q <= r_cnt_q + 1'b1;
            end
            r_tick_q <= 1'b0;
        end
    end

    assign o_tick = r_tick_q;
    assign o_wrap = w_wrap && !i_clear;

endmodule : baudctrl_divcnt_module

`default_nettype wire

// File: rtl/baudctrl_module.sv
// ============================================================================
//  Module      : baudctrl_module
//  Description : Baud-rate tick generator with a run-time divisor update
//                handshake. New divisors are applied only at a period
//                boundary (or at once while the counter is stopped).
//  Config      : define BAUDCTRL_BITTICK_EN to build the one-per-bit tick
//                (o_bittick); otherwise o_bittick is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baudctrl_module
    import baudctrl_pkg::*;
#(
    parameter int NB_BAUDCTRL_DIV  = C_NB_DIV_DEF,
    parameter int DEF_BAUDCTRL_DIV = C_DIV_DEF,
    parameter int MIN_BAUDCTRL_DIV = C_DIV_MIN
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_div_valid,
    input  logic [NB_BAUDCTRL_DIV-1:0] i_div_data,
    output logic                       o_div_ready,
    output logic                       o_div_err,
    output logic                       o_tick,
    output logic                       o_bittick,
    output logic [NB_BAUDCTRL_DIV-1:0] o_active_div
);

    logic [1:0]                 r_state_q;
    logic [1:0]                 w_state_d;
    logic [NB_BAUDCTRL_DIV-1:0] r_pending_q;
    logic [NB_BAUDCTRL_DIV-1:0] r_active_q;
    logic                       r_err_q;
    logic                       w_accept;
    logic                       w_div_ok;
    logic                       w_clear;
    logic                       w_wrap;

    assign o_div_ready = (r_state_q == C_ST_IDLE);
    assign w_accept    = i_div_valid && o_div_ready;
    assign w_div_ok    = (i_div_data >= NB_BAUDCTRL_DIV'(MIN_BAUDCTRL_DIV));
    assign w_clear     = (r_state_q == C_ST_APPLY);

    baudctrl_divcnt_module #(
        .NB_BAUDCTRL_DIV (NB_BAUDCTRL_DIV)
    ) u_divcnt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_clear   (w_clear),
        .i_divisor (r_active_q),
        .o_tick    (o_tick),
        .o_wrap    (w_wrap)
    );

    // Next-state: hold a pending divisor until the period boundary or a stop
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            C_ST_IDLE: begin
                if (w_accept && w_div_ok) begin
                    w_state_d = C_ST_PENDING;
                end
            end
            C_ST_PENDING: begin
                if (!i_enable || w_wrap) begin
                    w_state_d = C_ST_APPLY;
                end
            end
            C_ST_APPLY: begin
                w_state_d = C_ST_IDLE;
            end
            default: begin
                w_state_d = C_ST_IDLE;
            end
        endcase
    end

    // State, pending/active divisor and error pulse registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state_q   <= C_ST_IDLE;
            r_pending_q <= '0;
            r_active_q  <= NB_BAUDCTRL_DIV'(DEF_BAUDCTRL_DIV);
            r_err_q     <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_err_q   <= w_accept && !w_div_ok;
            if (w_accept && w_div_ok) begin
                r_pending_q <= i_div_data;
            end
            if (w_clear) begin
                r_active_q <= r_pending_q;
            end
        end
    end

    assign o_div_err    = r_err_q;
    assign o_active_div = r_active_q;

`ifdef BAUDCTRL_BITTICK_EN
    logic [C_NB_OVS-1:0] r_bitcnt_q;
    logic                r_bittick_q;

    // Bit sub-counter: every oversample-th wrap produces a bit tick
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_bitcnt_q  <= '0;
            r_bittick_q <= 1'b0;
        end else if (w_clear) begin
            r_bitcnt_q  <= '0;
            r_bittick_q <= 1'b0;
        end else if (w_wrap) begin
            r_bitcnt_q  <= r_bitcnt_q + 1'b1;
            r_bittick_q <= (r_bitcnt_q == C_NB_OVS'(C_OVERSAMPLE - 1));
        end else begin
            r_bittick_q <= 1'b0;
        end
    end

    assign o_bittick = r_bittick_q;
`else
    assign o_bittick = 1'b0;
`endif

endmodule : baudctrl_module

`default_nettype wire
